dsi_lanes_controller: RTL and testbench

- Upstream sequencer for the HS lane instances: one clock-lane instance (MODE=1) and LANES data-lane instances (MODE=0).
- Accepts one packet as a byte-lane stream with valid/ready/last handshake.
- Brings up the clock lane, starts all data lanes together and feeds one byte per lane per cycle.
- Ends the burst with fin requests, then stops the clock lane after a post-delay.
- Sits between the packet assembler and the HS lanes.

---
 rtl/dsi_lanes_controller.sv | 213 +++++++++++++++++++++
 tb/tb_dsi_lanes_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_lanes_controller.sv
// -----------------------------------------------------------------------------
// dsi_lanes_controller
//
// Upstream sequencer for the HS lanes. It runs one clock-lane instance and
// LANES data-lane instances. It takes one packet as a byte-lane stream,
// brings up the clock lane and then starts all data lanes together. It feeds
// one byte per lane per cycle, closes the burst with fin requests, and stops
// the clock lane after a post-delay.
//
// Optional feature: define DSI_CONT_CLK_EN for continuous clock mode. In that
// mode the clock lane is brought up once and never stopped. Each later packet
// goes from CLK_POST straight to DATA_START, so clk_fin_rqst never fires and
// busy stays high after the first burst.
//
// Parameters:
//   LANES            number of data lanes (1..4)
//   CLK_PRE_CYCLES   cycles from clk_active high to the data-lane start pulse
//   CLK_POST_CYCLES  cycles spent in CLK_POST before the clock lane is stopped
//
// Ports:
//   clk, rst         byte clock; asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready
//                    packet stream; lane i takes s_tdata[8i+7:8i]
//   clk_start_rqst   one-cycle start pulse to the clock lane
//   clk_fin_rqst     one-cycle finish pulse to the clock lane
//   clk_active       clock lane is running
//   clk_fin_ack      clock lane trail done
//   lane_start_rqst  one-cycle common start pulse to the data lanes
//   lane_fin_rqst    common finish, coincident with the last accepted beat
//   lane_data        bytes to the data lanes
//   lane_data_rqst   per-lane data request
//   lane_fin_ack     per-lane trail done
//   busy             high whenever the sequencer is not idle
//   underflow_err    sticky: lanes wanted data but none was valid
// -----------------------------------------------------------------------------
module dsi_lanes_controller #(
  parameter int LANES           = 4,
  parameter int CLK_PRE_CYCLES  = 4,
  parameter int CLK_POST_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES*8-1:0] s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic               clk_start_rqst,
  output logic               clk_fin_rqst,
  input  logic               clk_active,
  input  logic               clk_fin_ack,
  output logic               lane_start_rqst,
  output logic               lane_fin_rqst,
  output logic [LANES*8-1:0] lane_data,
  input  logic [LANES-1:0]   lane_data_rqst,
  input  logic [LANES-1:0]   lane_fin_ack,
  output logic               busy,
  output logic               underflow_err
);

  // The counter is shared between the pre-delay and the post-delay. It only
  // has to hold values up to the larger delay minus one.
  localparam int CNT_MAX = (CLK_PRE_CYCLES > CLK_POST_CYCLES) ? CLK_PRE_CYCLES : CLK_POST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE,
    CLK_START,
    CLK_WAIT,
    DATA_START,
    DATA_SEND,
    DATA_TRAIL,
    CLK_POST,
    CLK_STOP,
    CLK_TRAIL
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               armed_reg, armed_next;      // pre-counter loaded for the current clk_active high period
  logic [LANES-1:0]   fin_mask_reg, fin_mask_next;
  logic [LANES*8-1:0] data_reg, data_next;        // last accepted word
  logic               underflow_reg, underflow_next;

  logic               all_rqst;
  logic [LANES-1:0]   fin_mask_all;
  logic [CNT_W-1:0]   pre_dec;

  assign all_rqst     = &lane_data_rqst;
  // An ack that arrives in the same cycle as the final missing bit counts at once.
  assign fin_mask_all = fin_mask_reg | lane_fin_ack;
  // On the first high cycle the counter loads PRE-1. After that it counts down,
  // so the start pulse lands exactly CLK_PRE_CYCLES cycles after the rise.
  assign pre_dec      = armed_reg ? (cnt_reg - CNT_W'(1)) : CNT_W'(CLK_PRE_CYCLES - 1);

  assign busy          = (state_reg != IDLE);
  assign underflow_err = underflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      armed_reg     <= 1'b0;
      fin_mask_reg  <= '0;
      data_reg      <= '0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      armed_reg     <= armed_next;
      fin_mask_reg  <= fin_mask_next;
      data_reg      <= data_next;
      underflow_reg <= underflow_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    armed_next      = armed_reg;
    fin_mask_next   = fin_mask_reg;
    data_next       = data_reg;
    underflow_next  = underflow_reg;
    s_tready        = 1'b0;
    clk_start_rqst  = 1'b0;
    clk_fin_rqst    = 1'b0;
    lane_start_rqst = 1'b0;
    lane_fin_rqst   = 1'b0;
    lane_data       = data_reg;

    case (state_reg)
      IDLE: begin
        armed_next = 1'b0;
        if (s_tvalid) state_next = CLK_START;
      end

      CLK_START: begin
        clk_start_rqst = 1'b1;
        underflow_next = 1'b0;
        armed_next     = 1'b0;
        state_next     = CLK_WAIT;
      end

      CLK_WAIT: begin
        if (!clk_active) begin
          // A drop means the count restarts from the top on the next rise.
          armed_next = 1'b0;
        end else begin
          cnt_next   = pre_dec;
          armed_next = 1'b1;
          if (pre_dec == '0) begin
            armed_next = 1'b0;
            state_next = DATA_START;
          end
        end
      end

      DATA_START: begin
        lane_start_rqst = 1'b1;
        state_next      = DATA_SEND;
      end

      DATA_SEND: begin
        s_tready = all_rqst;
        if (all_rqst && s_tvalid) begin
          lane_data = s_tdata;
          data_next = s_tdata;
          if (s_tlast) begin
            lane_fin_rqst = 1'b1;
            fin_mask_next = '0;
            state_next    = DATA_TRAIL;
          end
        end else if (all_rqst) begin
          // The lanes consume the held word again. Flag the gap.
          underflow_next = 1'b1;
        end
      end

      DATA_TRAIL: begin
        fin_mask_next = fin_mask_all;
        if (&fin_mask_all) begin
          fin_mask_next = '0;
          cnt_next      = CNT_W'(CLK_POST_CYCLES - 1);
          state_next    = CLK_POST;
        end
      end

      CLK_POST: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
`ifdef DSI_CONT_CLK_EN
          // The clock stays up. Wait here for the next packet.
          if (s_tvalid) state_next = DATA_START;
`else
          state_next = CLK_STOP;
`endif
        end
      end

      CLK_STOP: begin
        clk_fin_rqst = 1'b1;
        state_next   = CLK_TRAIL;
      end

      CLK_TRAIL: begin
        if (clk_fin_ack) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dsi_lanes_controller.sv
// -----------------------------------------------------------------------------
// tb_dsi_lanes_controller
//
// Directed burst sequence with randomized data, lane request patterns and
// fin-ack skews. A small reference model predicts every observable value.
// The model tracks the held word, the sticky underflow flag and the expected
// cycle of every pulse. Inputs change 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dsi_lanes_controller;

  localparam int LANES = 4;
  localparam int PRE   = 4;
  localparam int POST  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [LANES*8-1:0] s_tdata;
  logic               s_tvalid;
  logic               s_tlast;
  logic               s_tready;
  logic               clk_start_rqst;
  logic               clk_fin_rqst;
  logic               clk_active;
  logic               clk_fin_ack;
  logic               lane_start_rqst;
  logic               lane_fin_rqst;
  logic [LANES*8-1:0] lane_data;
  logic [LANES-1:0]   lane_data_rqst;
  logic [LANES-1:0]   lane_fin_ack;
  logic               busy;
  logic               underflow_err;

  dsi_lanes_controller #(
    .LANES(LANES),
    .CLK_PRE_CYCLES(PRE),
    .CLK_POST_CYCLES(POST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tready(s_tready),
    .clk_start_rqst(clk_start_rqst),
    .clk_fin_rqst(clk_fin_rqst),
    .clk_active(clk_active),
    .clk_fin_ack(clk_fin_ack),
    .lane_start_rqst(lane_start_rqst),
    .lane_fin_rqst(lane_fin_rqst),
    .lane_data(lane_data),
    .lane_data_rqst(lane_data_rqst),
    .lane_fin_ack(lane_fin_ack),
    .busy(busy),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] held_word;     // last accepted word, 0 after reset
  bit          uf_model;      // sticky underflow expectation
  bit          cont_started;  // continuous mode: clock lane already up
  logic [31:0] words [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_tready"}, {31'd0, s_tready}, 32'd0);
    check({tag, "_clk_start"}, {31'd0, clk_start_rqst}, 32'd0);
    check({tag, "_clk_fin"}, {31'd0, clk_fin_rqst}, 32'd0);
    check({tag, "_lane_start"}, {31'd0, lane_start_rqst}, 32'd0);
    check({tag, "_lane_fin"}, {31'd0, lane_fin_rqst}, 32'd0);
    check({tag, "_lane_data"}, lane_data, 32'd0);
    check({tag, "_underflow"}, {31'd0, underflow_err}, 32'd0);
  endtask

  // One packet from request to clock stop.
  //   nbeats     packet length (words[] holds the data)
  //   gap_beat   beat before which s_tvalid drops for one cycle while all lanes request (-1: none)
  //   rand_rqst  randomly drop one lane's data request
  //   glitch     clk_active drops once before the pre-count completes
  //   abort_beat pulse rst before offering this beat (-1: none)
  task automatic run_burst(input string name, input int nbeats, input int gap_beat,
                           input bit rand_rqst, input bit glitch, input int abort_beat);
    int  b;
    int  cyc;
    bit  gap_done;
    bit  ready_exp;
    bit  acc;
    int  sk [LANES];
    int  jmax;

    s_tdata  = words[0];
    s_tlast  = (nbeats == 1);
    s_tvalid = 1'b1;

    if (!cont_started) begin
      sample();
      check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
      check({name, "_idle_ready"}, {31'd0, s_tready}, 32'd0);
      step();
      // CLK_START
      sample();
      check({name, "_clk_start"}, {31'd0, clk_start_rqst}, 32'd1);
      check({name, "_start_ready"}, {31'd0, s_tready}, 32'd0);
      check({name, "_uf_held"}, {31'd0, underflow_err}, {31'd0, uf_model});
      step();
      uf_model = 1'b0;
      for (int i = 0; i < 2; i++) begin
        sample();
        check({name, "_wait_inactive"}, {31'd0, lane_start_rqst}, 32'd0);
        if (i == 0) check({name, "_uf_cleared"}, {31'd0, underflow_err}, 32'd0);
        check({name, "_wait_clk_start"}, {31'd0, clk_start_rqst}, 32'd0);
        step();
      end
      if (glitch) begin
        clk_active = 1'b1;
        for (int i = 0; i < PRE - 1; i++) begin
          sample();
          check({name, "_glitch_high"}, {31'd0, lane_start_rqst}, 32'd0);
          step();
        end
        clk_active = 1'b0;
        sample();
        check({name, "_glitch_low"}, {31'd0, lane_start_rqst}, 32'd0);
        step();
      end
      clk_active = 1'b1;
      for (int i = 0; i < PRE; i++) begin
        sample();
        check({name, "_pre_count"}, {31'd0, lane_start_rqst}, 32'd0);
        step();
      end
    end else begin
      // Continuous mode: idling in CLK_POST with the clock running
      sample();
      check({name, "_cont_hold"}, {31'd0, lane_start_rqst}, 32'd0);
      check({name, "_cont_no_clk_start"}, {31'd0, clk_start_rqst}, 32'd0);
      step();
    end

    // DATA_START
    sample();
    check({name, "_lane_start"}, {31'd0, lane_start_rqst}, 32'd1);
    check({name, "_no_clk_start"}, {31'd0, clk_start_rqst}, 32'd0);
    check({name, "_ds_ready"}, {31'd0, s_tready}, 32'd0);
    step();

    // DATA_SEND: lanes start requesting 2 cycles after the start pulse
    b = 0; cyc = 0; gap_done = 1'b0;
    while (b < nbeats) begin
      if (cyc == 0) begin
        lane_data_rqst = '0;
      end else begin
        lane_data_rqst = '1;
        if (rand_rqst && $urandom_range(0, 3) == 0)
          lane_data_rqst[$urandom_range(0, LANES - 1)] = 1'b0;
      end
      if (b == gap_beat && !gap_done && (&lane_data_rqst)) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = $urandom;
        gap_done = 1'b1;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = words[b];
        s_tlast  = (b == nbeats - 1);
      end

      if (b == abort_beat) begin
        #2;
        rst = 1'b1;
        #1;
        check_all_zero({name, "_async_rst"});
        @(posedge clk);
        #1;
        rst            = 1'b0;
        s_tvalid       = 1'b0;
        s_tlast        = 1'b0;
        lane_data_rqst = '0;
        clk_active     = 1'b0;
        held_word      = '0;
        uf_model       = 1'b0;
        cont_started   = 1'b0;
        sample();
        check_all_zero({name, "_post_rst"});
        step();
        $display("burst %s: aborted by reset before beat %0d", name, b);
        return;
      end

      sample();
      ready_exp = &lane_data_rqst;
      acc       = ready_exp && s_tvalid;
      check({name, "_tready"}, {31'd0, s_tready}, {31'd0, ready_exp});
      check({name, "_lane_data"}, lane_data, acc ? words[b] : held_word);
      check({name, "_lane_fin"}, {31'd0, lane_fin_rqst}, {31'd0, (acc && b == nbeats - 1)});
      check({name, "_underflow"}, {31'd0, underflow_err}, {31'd0, uf_model});
      if (ready_exp && !s_tvalid) uf_model = 1'b1;
      if (acc) begin
        $display("burst %s: beat %0d data=%h last=%0d", name, b, words[b], (b == nbeats - 1));
        held_word = words[b];
        b++;
      end
      step();
      cyc++;
      if (cyc > 200) begin
        check({name, "_send_timeout"}, b, nbeats);
        return;
      end
    end

    // DATA_TRAIL: staggered acks; lane 0 first, lane LANES-1 two cycles later
    for (int i = 0; i < LANES; i++) sk[i] = $urandom_range(0, 2);
    sk[0] = 0;
    sk[LANES - 1] = 2;
    // All acks are in at trail cycle 3, CLK_POST spans cycles 4..3+POST
`ifdef DSI_CONT_CLK_EN
    jmax = 4 + POST + 2;
`else
    jmax = 4 + POST;
`endif
    for (int j = 0; j <= jmax; j++) begin
      for (int i = 0; i < LANES; i++) lane_fin_ack[i] = (j == 1 + sk[i]);
      s_tvalid = (j < 4);          // must not be accepted in the trail
      s_tdata  = $urandom;
      s_tlast  = 1'b1;
      lane_data_rqst = '1;
      sample();
      check({name, "_trail_ready"}, {31'd0, s_tready}, 32'd0);
      check({name, "_trail_lane_fin"}, {31'd0, lane_fin_rqst}, 32'd0);
      check({name, "_trail_busy"}, {31'd0, busy}, 32'd1);
`ifdef DSI_CONT_CLK_EN
      check({name, "_cont_no_clk_fin"}, {31'd0, clk_fin_rqst}, 32'd0);
`else
      check({name, "_clk_fin"}, {31'd0, clk_fin_rqst}, {31'd0, (j == 4 + POST)});
`endif
      step();
    end
    lane_fin_ack   = '0;
    lane_data_rqst = '0;
    s_tvalid       = 1'b0;
    s_tlast        = 1'b0;

`ifdef DSI_CONT_CLK_EN
    cont_started = 1'b1;
`else
    // CLK_TRAIL
    for (int i = 0; i < 2; i++) begin
      sample();
      check({name, "_clk_trail_busy"}, {31'd0, busy}, 32'd1);
      check({name, "_clk_trail_fin"}, {31'd0, clk_fin_rqst}, 32'd0);
      step();
    end
    clk_fin_ack = 1'b1;
    clk_active  = 1'b0;
    sample();
    check({name, "_ack_cycle_busy"}, {31'd0, busy}, 32'd1);
    step();
    clk_fin_ack = 1'b0;
    sample();
    check({name, "_idle_after_ack"}, {31'd0, busy}, 32'd0);
    check({name, "_idle_clk_start"}, {31'd0, clk_start_rqst}, 32'd0);
    step();
`endif
    $display("burst %s: complete, %0d beats, underflow=%0d", name, nbeats, uf_model);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    s_tdata        = '0;
    s_tvalid       = 1'b0;
    s_tlast        = 1'b0;
    clk_active     = 1'b0;
    clk_fin_ack    = 1'b0;
    lane_data_rqst = '0;
    lane_fin_ack   = '0;
    held_word      = '0;
    uf_model       = 1'b0;
    cont_started   = 1'b0;

    #3;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample();
    check_all_zero("after_reset");
    step();

    // Three-beat packet with known words
    words[0] = 32'h03020100;
    words[1] = 32'h07060504;
    words[2] = 32'h0B0A0908;
    run_burst("three_beat", 3, -1, 1'b0, 1'b0, -1);

    // Single-beat packet
    words[0] = 32'hAABBCCDD;
    run_burst("single", 1, -1, 1'b0, 1'b0, -1);

    // Underflow gap mid-packet
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    run_burst("underflow", 5, 2, 1'b0, 1'b0, -1);

    // Random lane requests, clk_active glitch; underflow clears at CLK_START
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    run_burst("rand_glitch", 4, -1, 1'b1, 1'b1, -1);

    // Reset in the middle of DATA_SEND, after an underflow
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    run_burst("abort", 4, 1, 1'b0, 1'b0, 3);

    // Clean packet after the reset
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_burst("after_abort", 3, -1, 1'b1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
